// File: rtl/apb_regfile_slave.sv
// APB register-bank responder: NUM_REGS x 32-bit read/write registers
// behind an APB slave port with programmable wait states and PSLVERR.
//
// Ports:
//   CLK      rising-edge clock
//   RST      asynchronous active-high reset
//   PSEL     this slave's select bit from the bridge decode
//   PENABLE  access-phase qualifier
//   PWRITE   1 = write, 0 = read
//   PADDR    byte offset within this slave's window
//   PWDATA   write data (captured in the setup cycle)
//   PRDATA   read data, non-zero only in the PREADY cycle of a good read
//   PREADY   transfer completion, high for exactly one cycle
//   PSLVERR  error response, high only in the PREADY cycle
module apb_regfile_slave #(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int          AW    = $clog2(NUM_REGS);
    localparam logic [31:0] LIMIT = 32'(NUM_REGS * 4);

    // WAIT: access phase, PREADY low. READY: the PREADY=1 cycle.
    // DONE: cycle after PREADY, may already carry the next setup.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic          r_err;
    logic          r_write;
    logic [31:0]   r_wdata;
    logic [31:0]   r_prdata;
    logic          r_pready;
    logic          r_pslverr;
    logic [31:0]   r_regs [NUM_REGS];

    logic [AW-1:0] w_idx;
    logic          w_err;
    logic          w_setup;

    assign w_idx   = PADDR[2 +: AW];
    assign w_err   = (PADDR[1:0] != 2'b00) || (PADDR >= LIMIT);
    assign w_setup = PSEL && !PENABLE;

    assign PRDATA  = r_prdata;
    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_write   <= 1'b0;
            r_wdata   <= 32'h0;
            r_prdata  <= 32'h0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else begin
            // Response outputs are single-cycle pulses by default.
            r_prdata  <= 32'h0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_setup) begin
                        r_idx   <= w_idx;
                        r_err   <= w_err;
                        r_write <= PWRITE;
                        r_wdata <= PWDATA;
                        if (WAIT_STATES == 0) begin
                            // No wait states: the first PENABLE cycle
                            // is already the PREADY cycle.
                            r_state   <= ST_READY;
                            r_cnt     <= 4'd0;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= (!PWRITE && !w_err) ?
                                         r_regs[w_idx] : 32'h0;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= 4'(WAIT_STATES);
                        end
                    end else begin
                        // Includes the illegal PSEL&PENABLE entry.
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!PSEL) begin
                        // Master abandoned the transfer.
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd1) begin
                        r_state   <= ST_READY;
                        r_cnt     <= 4'd0;
                        r_pready  <= 1'b1;
                        r_pslverr <= r_err;
                        r_prdata  <= (!r_write && !r_err) ?
                                     r_regs[r_idx] : 32'h0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_READY: begin
                    // Commit on the edge that closes the PREADY cycle,
                    // so a back-to-back read already sees the new value.
                    if (r_write && !r_err) begin
                        r_regs[r_idx] <= r_wdata;
                    end
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench for apb_regfile_slave: three instances share one
// APB bus behind a one-hot select, each with its own wait-state count.
module tb_apb_regfile_slave;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    int ws [3] = '{1, 0, 3};
    int nr [3] = '{8, 8, 4};

    logic        clk = 1'b0;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    int          sel;

    logic [2:0]  ps;
    logic [31:0] prd [3];
    logic        rdy [3];
    logic        err [3];

    logic [31:0] m_prd;
    logic        m_rdy;
    logic        m_err;

    logic [31:0] mem [3][256];
    exp_t        q [$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    assign ps[0] = psel && (sel == 0);
    assign ps[1] = psel && (sel == 1);
    assign ps[2] = psel && (sel == 2);

    apb_regfile_slave #(.NUM_REGS(8), .WAIT_STATES(1)) u_d0 (
        .CLK(clk), .RST(rst), .PSEL(ps[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prd[0]), .PREADY(rdy[0]), .PSLVERR(err[0])
    );

    apb_regfile_slave #(.NUM_REGS(8), .WAIT_STATES(0)) u_d1 (
        .CLK(clk), .RST(rst), .PSEL(ps[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prd[1]), .PREADY(rdy[1]), .PSLVERR(err[1])
    );

    apb_regfile_slave #(.NUM_REGS(4), .WAIT_STATES(3)) u_d2 (
        .CLK(clk), .RST(rst), .PSEL(ps[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prd[2]), .PREADY(rdy[2]), .PSLVERR(err[2])
    );

    always_comb begin
        m_prd = prd[0];
        m_rdy = rdy[0];
        m_err = err[0];
        case (sel)
            1: begin m_prd = prd[1]; m_rdy = rdy[1]; m_err = err[1]; end
            2: begin m_prd = prd[2]; m_rdy = rdy[2]; m_err = err[2]; end
            default: ;
        endcase
    end

    // Monitor: every PREADY pops one expected response.
    always @(negedge clk) begin
        exp_t e;
        tests++;
        if (m_rdy) begin
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pready sel=%0d prdata=%h",
                         sel, m_prd);
            end else begin
                e = q.pop_front();
                if (m_prd !== e.rd || m_err !== e.err) begin
                    fails++;
                    $display("FAIL response sel=%0d got %h/%b exp %h/%b",
                             sel, m_prd, m_err, e.rd, e.err);
                end
            end
        end else begin
            if (m_prd !== 32'h0 || m_err !== 1'b0) begin
                fails++;
                $display("FAIL idle_outputs sel=%0d got %h/%b exp 0/0",
                         sel, m_prd, m_err);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (k != sel && rdy[k] !== 1'b0) begin
                fails++;
                $display("FAIL unselected_ready dut=%0d got 1 exp 0", k);
            end
        end
    end

    task automatic model_reset();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 256; i++)
                mem[d][i] = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int d, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit chg);
        exp_t e;
        int   cnt;
        bit   er;
        er = (a[1:0] != 2'b00) || (a >= 32'(nr[d] * 4));
        e.err = er;
        e.rd  = (!wr && !er) ? mem[d][a >> 2] : 32'h0;
        if (wr && !er) mem[d][a >> 2] = wd;
        q.push_back(e);
        sel = d; psel = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        if (chg) pwdata = 32'hFFFF_FFFF;
        cnt = 0;
        @(negedge clk);
        while (!m_rdy && cnt <= 40) begin
            cnt++;
            @(negedge clk);
        end
        tests++;
        if (cnt != ws[d]) begin
            fails++;
            $display("FAIL latency dut=%0d addr=%h got %0d exp %0d",
                     d, a, cnt, ws[d]);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic abort_xfer(input int d, input logic [31:0] a,
                              input logic [31:0] wd);
        sel = d; psel = 1'b1; penable = 1'b0;
        pwrite = 1'b1; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        idle(3);
    endtask

    task automatic illegal_entry(input int d);
        sel = d; psel = 1'b1; penable = 1'b1;
        pwrite = 1'b0; paddr = 32'h0;
        idle(3);
        psel = 1'b0; penable = 1'b0;
        idle(1);
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    initial begin
        int          d;
        int          r;
        int          idx;
        logic [31:0] a;
        rst = 1'b1; sel = 0; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        check("reset_pready", {31'h0, m_rdy}, 32'h0);
        check("reset_prdata", m_prd, 32'h0);

        xfer(0, 1'b0, 32'h00, 32'h0, 1'b0);
        xfer(0, 1'b1, 32'h1C, 32'hDEADBEEF, 1'b0);
        xfer(0, 1'b0, 32'h1C, 32'h0, 1'b0);
        idle(1);

        xfer(0, 1'b1, 32'h20, 32'h12345678, 1'b0);
        xfer(0, 1'b1, 32'h06, 32'h12345678, 1'b0);
        for (int i = 0; i < 8; i++)
            xfer(0, 1'b0, 32'(i * 4), 32'h0, 1'b0);
        idle(1);

        xfer(1, 1'b1, 32'h04, 32'hA5A5A5A5, 1'b1);
        xfer(1, 1'b0, 32'h04, 32'h0, 1'b0);
        idle(1);

        xfer(2, 1'b1, 32'h08, 32'h77, 1'b0);
        abort_xfer(2, 32'h08, 32'h55);
        xfer(2, 1'b0, 32'h08, 32'h0, 1'b0);
        illegal_entry(0);

        for (int n = 0; n < 300; n++) begin
            d   = $urandom_range(0, 2);
            r   = $urandom_range(0, 9);
            idx = $urandom_range(0, nr[d] - 1);
            if (r <= 6)      a = 32'(idx * 4);
            else if (r == 7) a = 32'(idx * 4 + $urandom_range(1, 3));
            else if (r == 8) a = 32'(nr[d] * 4 + 4 * $urandom_range(0, 15));
            else             a = $urandom();
            xfer(d, 1'($urandom_range(0, 1)), a, $urandom(),
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        xfer(2, 1'b1, 32'h0C, 32'h33, 1'b0);
        xfer(1, 1'b1, 32'h0C, 32'h11, 1'b0);
        idle(1);
        sel = 1; psel = 1'b1; penable = 1'b0;
        pwrite = 1'b0; paddr = 32'h0C;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        check("pre_reset_ready", {31'h0, rdy[1]}, 32'h1);
        check("pre_reset_prdata", prd[1], 32'h11);
        rst = 1'b1;
        #1;
        check("reset_mid_pready", {31'h0, rdy[1]}, 32'h0);
        check("reset_mid_prdata", prd[1], 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle(1);
        xfer(1, 1'b0, 32'h0C, 32'h0, 1'b0);
        xfer(2, 1'b0, 32'h0C, 32'h0, 1'b0);
        idle(2);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain got %0d exp 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
- APB responder at the far end of the AHB-to-APB slave decode: consumes one bit of the bridge's one-hot PSEL_slave vector and returns its word on the matching PRData_slave lane.
- Implements NUM_REGS 32-bit read/write registers with a configurable wait-state count, PREADY and PSLVERR.
- Serves as the team's generic peripheral register bank and bridge test target.

Parameters:
- NUM_REGS, 8: number of 32-bit registers; power of two, 2..256.
- WAIT_STATES, 1: PREADY-low cycles inserted in each access phase, 0..15.
- RESET_VAL, 32'h0000_0000: reset value of every register.

Ports:
- CLK  input  1  clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- PSEL  input  1  select from bridge decode (one bit of PSEL_slave).
- PENABLE  input  1  access-phase qualifier.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  32  byte address, offset within this slave's window.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data, drives this slave's PRData_slave lane.
- PREADY  output  1  transfer completion.
- PSLVERR  output  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (async assert, sync deassert by the surrounding design): state=IDLE; all registers=RESET_VAL; PRDATA=0, PREADY=0, PSLVERR=0; wait counter=0.
- Address decode:
  - idx = PADDR[2 +: log2(NUM_REGS)].
  - Error when PADDR[1:0]!=0 or PADDR >= NUM_REGS*4.
  - Decode is captured in the SETUP cycle (PSEL=1, PENABLE=0), along with PWRITE and PWDATA.
- FSM:
  - IDLE: PSEL=1 and PENABLE=0 -> SETUP. PSEL=1 and PENABLE=1 is an illegal entry: ignore it and stay in IDLE.
  - SETUP (one cycle): load cnt=WAIT_STATES -> ACCESS.
  - ACCESS, cnt>0: PREADY=0; cnt decrements each cycle.
  - ACCESS, cnt==0: PREADY=1 for exactly one cycle -> DONE.
  - DONE: PREADY=0. PSEL=1 and PENABLE=0 -> SETUP (back-to-back transfer, no idle cycle required). Otherwise -> IDLE.
  - Any state: PSEL=0 before PREADY is given means the transfer is aborted -> IDLE, no register update, outputs return to 0.
- Outputs are registered. The PREADY cycle is first visible in the cycle after the last wait cycle.
- Access-phase latency from PENABLE rising: WAIT_STATES+1 cycles. With WAIT_STATES=0, PREADY is high in the first PENABLE cycle.
- Writes:
  - The register updates on the clock edge that ends the PREADY=1 cycle, only if there is no error.
  - Write data is the value captured in SETUP; later PWDATA changes are ignored.
- Reads:
  - PRDATA = reg[idx] as sampled in the PREADY cycle, held only during that cycle, 0 at all other times.
  - On error, PRDATA=0.
- Errors: PSLVERR=1 only in the PREADY cycle of an errored transfer. An errored write leaves all registers unchanged.
- Simultaneous events: a read of the register written by the immediately preceding back-to-back transfer returns the new value.
- Reset mid-transfer: the transfer is aborted immediately, registers return to RESET_VAL, and PREADY stays 0 until a fresh SETUP.

Test Plan:
- Reset, then read addr 0x0 with WAIT_STATES=1 -> PREADY high 2 cycles after PENABLE rises, PRDATA=0x00000000, PSLVERR=0.
- Write 0xDEADBEEF to 0x1C, then back-to-back read 0x1C -> second transfer returns PRDATA=0xDEADBEEF; no idle cycle between the transfers.
- Write 0x12345678 to 0x20 (NUM_REGS=8) and to 0x06 -> PSLVERR=1 in each PREADY cycle; a read sweep of 0x00..0x1C shows every register unchanged.
- WAIT_STATES=0, write 0xA5A5A5A5 to 0x04 -> PREADY=1 in the first PENABLE cycle; PWDATA changed to 0xFFFFFFFF in the access phase is ignored; readback gives 0xA5A5A5A5.
- Write 0x55 to 0x08, drop PSEL during a wait cycle (WAIT_STATES=3) -> no PREADY; FSM returns to IDLE; readback of 0x08 gives its old value.
- Assert RST during the ACCESS phase after writing 0x11 to 0x0C -> PREADY=0 and PRDATA=0 immediately; readback of 0x0C gives RESET_VAL.
